// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: FSM states and captured response record for the APB requester.
package apb_requester_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              timeout;
    } rsp_t;

endpackage

// File: rtl/apb_requester.sv
// apb_requester: one-shot command strobe to a single APB3 transfer with a one-cycle response pulse.
// Define APB_REQUESTER_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_en,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  cmd_dropped,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    if (DATA_WIDTH != DATA_W) begin : g_bad_width
        $error("apb_requester: DATA_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t                state_q, state_d;
    logic                  psel_q, psel_d, penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  cmd_dropped_q, cmd_dropped_d;
    logic                  to_hit;

`ifdef APB_REQUESTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = state_q == SETUP ? 16'd0 : state_q == ACCESS ? cnt_q + 16'd1 : cnt_q;
    end
    assign to_hit = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_d         = rsp_q;
        cmd_dropped_d = cmd_dropped_q | (cmd_en & (state_q != IDLE));
        unique case (state_q)
            IDLE: if (cmd_en) begin
                state_d  = SETUP;
                pwrite_d = cmd_write;
                paddr_d  = cmd_addr;
                pwdata_d = cmd_wdata;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_d       = '{rdata: pwrite_q ? '0 : prdata, err: pslverr, timeout: 1'b0};
            end else if (to_hit) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_d       = '{rdata: '0, err: 1'b1, timeout: 1'b1};
            end
            default: state_d = IDLE;
        endcase
        // Bus strobes are registered copies of the next state so they never glitch.
        psel_d    = state_d != IDLE;
        penable_d = state_d == ACCESS;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_q         <= '0;
            cmd_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_q         <= rsp_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

    assign cmd_ready   = state_q == IDLE;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign cmd_dropped = cmd_dropped_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: vector table plus corner sequences, scoreboarded against rsp_valid pulses.
module tb_apb_requester;

    logic        pclk = 0, preset_n = 0;
    logic        cmd_en = 0, cmd_write = 0;
    logic [15:0] cmd_addr = 0;
    logic [31:0] cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, cmd_dropped;
    logic [31:0] rsp_rdata, pwdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic        pready = 0, pslverr = 0;
    logic [31:0] prdata = 0;

    apb_requester #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .preset_n(preset_n), .cmd_en(cmd_en), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .cmd_dropped(cmd_dropped), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          at;
    } exp_t;

    int          n_cmp = 0, n_fail = 0, cyc = 0;
    int          cur_waits = 0, acc_cnt = 0;
    logic        cur_wr = 0, cur_slverr = 0;
    logic [15:0] cur_addr = 0;
    logic [31:0] cur_wdata = 0, cur_prdata = 0, last_rdata = 0;
    exp_t        q[$];
    vec_t        vecs[$];

    always @(posedge pclk) cyc++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completer: asserts pready after cur_waits wait states of ACCESS.
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready  = acc_cnt == cur_waits;
            pslverr = pready & cur_slverr;
            prdata  = pready ? cur_prdata : 32'h0BAD_0BAD;
            if (pready) begin
                chk("paddr", 32'(paddr), 32'(cur_addr));
                chk("pwrite", 32'(pwrite), 32'(cur_wr));
                if (cur_wr) chk("pwdata", pwdata, cur_wdata);
            end
            acc_cnt++;
        end else begin
            pready  = 0;
            pslverr = 0;
            acc_cnt = 0;
        end
    end

    always @(negedge pclk) begin
        exp_t e;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 required no response (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                chk("rsp_cycle", cyc, e.at);
                chk("rsp_psel", 32'(psel), 0);
                chk("rsp_cmd_ready", 32'(cmd_ready), 1);
                last_rdata = e.rdata;
            end
        end
    end

    task automatic issue(vec_t v);
        int k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge pclk);
            k++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cur_wr = v.wr; cur_addr = v.addr; cur_wdata = v.wdata;
        cur_waits = v.waits; cur_prdata = v.prdata; cur_slverr = v.slverr;
        q.push_back('{v.exp_rdata, v.exp_err, v.exp_tmo, cyc + v.lat});
        cmd_en = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(negedge pclk);
        cmd_en = 0;
        chk("setup_psel", 32'(psel), 1);
        chk("setup_penable", 32'(penable), 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge pclk);
            k++;
        end
        chk("rsp_wait", q.size(), 0);
        @(negedge pclk);
        chk("rsp_pulse_len", 32'(rsp_valid), 0);
        chk("rsp_hold", rsp_rdata, last_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        vecs.push_back('{1'b1, 16'h0000, 32'h0000_8002, 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 16'h0020, 32'h0, 3, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 6});
        vecs.push_back('{1'b0, 16'h0010, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b1, 16'h1234, 32'hA5A5_A5A5, 1, 32'h5555_5555, 1'b1, 32'h0, 1'b1, 1'b0, 4});
        vecs.push_back('{1'b0, 16'hFFFF, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 16'h0044, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 6});
`ifdef APB_REQUESTER_TIMEOUT_EN
        vecs.push_back('{1'b0, 16'h0040, 32'h0, 1000, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b1, 6});
        vecs.push_back('{1'b1, 16'h0048, 32'h7777_0001, 3, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6});
`endif
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_outputs", {26'b0, rsp_valid, rsp_err, rsp_timeout, cmd_dropped, psel, penable}, 0);
        chk("rst_bus", {15'b0, pwrite, paddr} | pwdata | rsp_rdata, 0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1;
        @(negedge pclk);

        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_done();
        end

        issue('{1'b0, 16'h0030, 32'h0, 2, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 5});
        @(negedge pclk);
        cmd_en = 1; cmd_write = 1; cmd_addr = 16'h0BAD; cmd_wdata = 32'hFFFF_0000;
        @(negedge pclk);
        cmd_en = 0;
        chk("cmd_dropped_set", 32'(cmd_dropped), 1);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge pclk);
            k++;
        end
        chk("b2b_rsp_seen", 32'(rsp_valid), 1);
        issue('{1'b1, 16'h0034, 32'h1357_9BDF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3});
        wait_done();
        chk("cmd_dropped_sticky", 32'(cmd_dropped), 1);

        issue('{1'b0, 16'h0050, 32'h0, 10, 32'h9999_9999, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 13});
        @(negedge pclk);
        #2 preset_n = 0;
        #1;
        chk("arst_psel", 32'(psel), 0);
        chk("arst_penable", 32'(penable), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_cmd_dropped", 32'(cmd_dropped), 0);
        q.delete();
        @(negedge pclk);
        preset_n = 1;
        @(negedge pclk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_psel", 32'(psel), 0);
        repeat (15) @(negedge pclk);
        issue('{1'b0, 16'h0008, 32'h0, 1, 32'h0BEE_F00D, 1'b0, 32'h0BEE_F00D, 1'b0, 1'b0, 4});
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB initiator that turns a one-shot command strobe (from the management CPU bridge, a debug UART, or a test sequencer) into a single APB3 transfer on an APB bus.
It drives SETUP/ACCESS phases, waits for pready, and returns read data and error status as a one-cycle response pulse.
It is the requester-side counterpart to the APB completer peripherals on the trigger I/O bus.
It connects to their bus segment directly or through the existing APB fabric.

Parameters:
ADDR_WIDTH, 16, width of paddr and cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata; any other value is a synthesis error
TIMEOUT_CYCLES, 255, max ACCESS-phase cycles before abort (used only with APB_REQUESTER_TIMEOUT_EN); range 1..65535

Ports:
pclk  in  1  sole clock; one clock; reset is asynchronous and active-low
preset_n  in  1  async active-low reset
cmd_en  in  1  start transfer; sampled only when cmd_ready=1
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_ready  out  1  high in IDLE only
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr or timeout; valid with rsp_valid
rsp_timeout  out  1  transfer aborted by timeout; valid with rsp_valid
cmd_dropped  out  1  sticky: cmd_en seen while cmd_ready=0; cleared only by reset
psel, penable, pwrite  out  1 each  APB requester controls
paddr  out  ADDR_WIDTH;  pwdata  out  DATA_WIDTH
pready, pslverr  in  1 each;  prdata  in  DATA_WIDTH

Behaviour:
- Reset (async, immediate): every output is 0 except cmd_ready=1; state=IDLE. A reset mid-transfer drops psel/penable at once and emits no response.
- States:
  - IDLE: cmd_en=1 latches write/addr/wdata, then goes to SETUP.
  - SETUP: exactly 1 cycle with psel=1, penable=0, then ACCESS.
  - ACCESS: psel=1, penable=1; held while pready=0.
- ACCESS exit on pready=1: capture prdata (reads only; writes capture 0) and pslverr, then go to IDLE.
- On the next cycle: rsp_valid=1 for exactly 1 cycle, psel=penable=0, cmd_ready=1.
- Latency with zero wait states:
  - cmd_en at cycle N; SETUP at N+1; ACCESS at N+2; rsp_valid at N+3.
  - Each wait state adds 1 cycle.
- Back-to-back: cmd_en may be accepted in the same cycle rsp_valid is high, giving SETUP at the next cycle (3-cycle throughput).
- paddr/pwrite/pwdata stay stable from SETUP through the final ACCESS cycle. In IDLE they retain their last values (no toggling).
- rsp_rdata/rsp_err/rsp_timeout hold their values until the next rsp_valid.
- cmd_en while cmd_ready=0 is ignored and sets cmd_dropped.

Optional Feature:
APB_REQUESTER_TIMEOUT_EN.
Defined:
- A 16-bit counter resets on SETUP and increments every ACCESS cycle.
- If pready=0 in the ACCESS cycle where the counter equals TIMEOUT_CYCLES-1, the FSM returns to IDLE.
- The response is then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- If pready=1 in that same cycle, the normal completion wins.
Undefined: ACCESS waits indefinitely; rsp_timeout is tied to 0; the counter is not built.

Decomposition:
- Package apb_requester_pkg holds the state_t enum (IDLE, SETUP, ACCESS) and the response struct {rdata, err, timeout}.
- The APB bus signal definitions stay in the shared APB types.
- No sub-module; the single always_ff FSM plus the optional counter is the whole block.

Test Plan:
- Write 0x0000 data 0x00008002, completer pready=1 first ACCESS cycle -> psel at N+1, penable at N+2, pwdata=0x00008002, rsp_valid at N+3, rsp_err=0.
- Read 0x0020, completer 3 wait states, prdata=0x00000001 -> ACCESS held 4 cycles, rsp_valid at N+6, rsp_rdata=0x00000001.
- Read unmapped 0x0010, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- cmd_en during ACCESS, then cmd_en in rsp_valid cycle -> first ignored with cmd_dropped=1; second starts SETUP the next cycle.
- TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, rsp_err=1, rsp_timeout=1. Repeat with pready=1 on the 4th cycle -> normal completion.
- preset_n low during ACCESS -> psel/penable 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
